// File: rtl/freq_meter_eq_if.sv
// Signal-under-test, enable and result bundle for freq_meter_eq.
// slave = meter side, master = the block driving sig_in/enable.
interface freq_meter_eq_if #(
    parameter int CNT_W = 32
);
    logic             sig_in;
    logic             enable;
    logic [CNT_W-1:0] nx;
    logic [CNT_W-1:0] ns;
    logic [CNT_W-1:0] hi;
    logic             valid;
    logic             timeout;
    logic             ovf;
    logic             busy;

    modport master (
        output sig_in, enable,
        input  nx, ns, hi, valid, timeout, ovf, busy
    );

    modport slave (
        input  sig_in, enable,
        output nx, ns, hi, valid, timeout, ovf, busy
    );
endinterface

// File: rtl/freq_meter_eq.sv
// Equal-precision frequency meter: the gate opens and closes on sig_in rises.
// Define FREQ_METER_DUTY_EN to build the high-time (duty) counter.
module freq_meter_eq #(
    parameter int CNT_W          = 32,
    parameter int GATE_CYCLES    = 200_000_000,
    parameter int IDLE_CYCLES    = 12_500_000,
    parameter int TIMEOUT_CYCLES = 400_000_000
) (
    input logic            clk,
    input logic            rst_n,
    freq_meter_eq_if.slave bus
);
    localparam int TMR_MAX = (GATE_CYCLES > TIMEOUT_CYCLES)
                           ? GATE_CYCLES : TIMEOUT_CYCLES;
    localparam int TMR_W = $clog2(TMR_MAX + 1);
    localparam int IDL_W = $clog2(IDLE_CYCLES + 1);

    localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDL_W-1:0] IDLE_LAST = IDL_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_MEAS,
        S_CLOSE,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       sync_q;
    logic             rise;
    logic [IDL_W-1:0] idle_q, idle_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] nx_cnt_q, nx_cnt_d;
    logic [CNT_W-1:0] ns_cnt_q, ns_cnt_d;
    logic             sat_q, sat_d;
    logic             cnt_en;
    logic             tmo_d;
    logic             load;
    logic [CNT_W-1:0] nx_q, ns_q;
    logic             valid_q, timeout_q, ovf_q, busy_q;

    // [0],[1] form the synchronizer; [2] is the previous synced level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[1:0], bus.sig_in};
    end

    assign rise = sync_q[1] & ~sync_q[2];

`ifdef FREQ_METER_DUTY_EN
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] hi_q;
`endif

    always_comb begin
        state_d  = state_q;
        idle_d   = idle_q;
        tmr_d    = tmr_q;
        nx_cnt_d = nx_cnt_q;
        ns_cnt_d = ns_cnt_q;
        sat_d    = sat_q;
        cnt_en   = 1'b0;
        tmo_d    = 1'b0;
`ifdef FREQ_METER_DUTY_EN
        hi_cnt_d = hi_cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (idle_q == IDLE_LAST) begin
                    idle_d  = '0;
                    state_d = S_ARM;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            S_ARM: begin
                tmr_d = tmr_q + 1'b1;
                if (rise) begin
                    state_d  = S_MEAS;
                    nx_cnt_d = '0;
                    ns_cnt_d = '0;
                    sat_d    = 1'b0;
`ifdef FREQ_METER_DUTY_EN
                    hi_cnt_d = '0;
`endif
                end else if (tmr_q >= TMO_LAST) begin
                    state_d = S_DONE;
                    tmo_d   = 1'b1;
                end
            end
            S_MEAS: begin
                tmr_d  = tmr_q + 1'b1;
                cnt_en = 1'b1;
                if (tmr_q >= GATE_LAST) begin
                    state_d = S_CLOSE;
                    tmr_d   = '0;
                end
            end
            S_CLOSE: begin
                tmr_d  = tmr_q + 1'b1;
                cnt_en = 1'b1;
                if (rise) begin
                    state_d = S_DONE;
                end else if (tmr_q >= TMO_LAST) begin
                    state_d = S_DONE;
                    tmo_d   = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (cnt_en) begin
            if (ns_cnt_q == CNT_MAX) sat_d = 1'b1;
            else                     ns_cnt_d = ns_cnt_q + 1'b1;
            if (rise) begin
                if (nx_cnt_q == CNT_MAX) sat_d = 1'b1;
                else                     nx_cnt_d = nx_cnt_q + 1'b1;
            end
`ifdef FREQ_METER_DUTY_EN
            if (sync_q[1]) begin
                if (hi_cnt_q == CNT_MAX) sat_d = 1'b1;
                else                     hi_cnt_d = hi_cnt_q + 1'b1;
            end
`endif
        end

        // enable low abandons any measurement without a result
        if (!bus.enable) begin
            state_d = S_IDLE;
            idle_d  = '0;
        end
    end

    assign load = (state_d == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idle_q   <= '0;
            tmr_q    <= '0;
            nx_cnt_q <= '0;
            ns_cnt_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idle_q   <= idle_d;
            tmr_q    <= tmr_d;
            nx_cnt_q <= nx_cnt_d;
            ns_cnt_q <= ns_cnt_d;
            sat_q    <= sat_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nx_q      <= '0;
            ns_q      <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= load;
            busy_q  <= (state_d == S_ARM)
                    || (state_d == S_MEAS)
                    || (state_d == S_CLOSE);
            if (load) begin
                nx_q      <= tmo_d ? '0 : nx_cnt_d;
                ns_q      <= tmo_d ? '0 : ns_cnt_d;
                timeout_q <= tmo_d;
                ovf_q     <= tmo_d ? 1'b0 : sat_d;
            end
        end
    end

`ifdef FREQ_METER_DUTY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt_q <= '0;
            hi_q     <= '0;
        end else begin
            hi_cnt_q <= hi_cnt_d;
            if (load) hi_q <= tmo_d ? '0 : hi_cnt_d;
        end
    end

    assign bus.hi = hi_q;
`else
    assign bus.hi = '0;
`endif

    assign bus.nx      = nx_q;
    assign bus.ns      = ns_q;
    assign bus.valid   = valid_q;
    assign bus.timeout = timeout_q;
    assign bus.ovf     = ovf_q;
    assign bus.busy    = busy_q;
endmodule
